icache_responder: RTL
=====================

Name: icache_responder

Overview:
- Direct-mapped instruction cache that sits between the pipeline fetch port and the memory controller.
- Answers the datapath's instruction fetch requests: imemREN/imemaddr in, ihit/imemload out.
- On a miss, issues single-word refills to memory (iREN/iaddr out, iwait/iload in) and fills the frame.
- Gives one-cycle hits and a counted miss path.

Parameters:
- SETS, 16, number of frames; power of two, minimum 2. IDX_W = log2(SETS); TAG_W = 30 - IDX_W.
- CNT_W, 16, width of the saturating miss counter.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset, synchronous, active-high.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address; bits [1:0] are ignored.
- ihit  out  1  fetch data valid this cycle.
- imemload  out  32  fetched instruction; 0 when ihit=0.
- inval  in  1  invalidate all frames (one-cycle pulse or level).
- iREN  out  1  refill read request to memory.
- iaddr  out  32  refill word address; bits [1:0] are always 00.
- iwait  in  1  memory busy; iwait=0 while iREN=1 means iload is valid this cycle.
- iload  in  32  refill data.
- miss_count  out  CNT_W  number of misses since reset; saturates.

Behaviour:
- Address split: tag = imemaddr[31:IDX_W+2], idx = imemaddr[IDX_W+1:2].
- Per frame: valid (1 bit), tag (TAG_W bits), data (32 bits).
- Reset (RST=1 at a rising edge): all valid=0, all tags and data=0, state=IDLE, miss_addr=0, miss_count=0.
- Outputs after reset: ihit=0, imemload=0, iREN=0, iaddr=0. RST overrides every other input in that cycle, including an in-progress FILL, which is abandoned without writing.
- State IDLE:
  - hit = imemREN & valid[idx] & (tag[idx]==addr tag).
  - ihit = hit, combinational, same cycle; imemload = data[idx] when hit.
  - If imemREN & !hit: latch miss_addr = {imemaddr[31:2],2'b00}, increment miss_count (hold at all-ones), go to FILL.
  - iREN=0 and iaddr=0 in IDLE.
- State FILL:
  - iREN=1, iaddr=miss_addr, ihit=0, imemload=0.
  - While iwait=1: stay in FILL.
  - When iwait=0: write frame[miss_addr idx] with valid=1, tag=miss_addr tag, data=iload; go to IDLE.
  - The fetch hits in the first IDLE cycle after that, provided imemaddr still maps to the filled frame.
- Miss latency: with memory holding iwait high for W cycles, ihit asserts W+2 cycles after the miss cycle (1 cycle to FILL, W wait cycles, 1 cycle fill complete).
- imemaddr changes during FILL: no effect. The refill completes for miss_addr; the new address is looked up normally in IDLE.
- imemREN drops during FILL: the refill still completes and the frame is written.
- inval:
  - In IDLE: clears all valid bits at the edge. ihit in that same cycle is still evaluated against the pre-clear state.
  - In FILL: clears all valid bits.
  - inval in the same cycle as fill completion: the fill's tag and data are written, but inval wins for the valid bit, so the frame ends invalid and the next lookup misses again.
- Conflict-miss replacement: a miss to an index already holding a different tag overwrites that frame; there is no writeback.
- The memory side must never see iREN=1 in IDLE or iaddr change while in FILL.

Test Plan:
- Cold miss then hit: RST, imemREN=1, imemaddr=0x0000_0040, memory W=3, iload=0x2001_0005 → iREN=1 and iaddr=0x40 for 4 cycles; ihit=1 with imemload=0x2001_0005 on the following cycle; miss_count=1.
- Repeated hit: after the above, imemaddr=0x0000_0040 for 5 cycles → ihit=1 every cycle, iREN=0, miss_count stays 1.
- Conflict miss: imemaddr=0x0000_0440 (same idx 0, different tag) → miss, refill from 0x440. Then 0x40 → miss again; miss_count=3.
- Address change mid-fill: miss at 0x0000_0008, change imemaddr to 0x0000_000C during the wait → iaddr stays 0x8. After the fill, 0xC misses and refills from 0xC; the frame for 0x8 is valid.
- Invalidate collision: assert inval in the same cycle iwait falls for miss_addr 0x10 → the next cycle's lookup of 0x10 misses and re-issues iREN.
- Reset mid-fill: RST during FILL with iwait=1 → the next cycle has iREN=0, ihit=0, miss_count=0, and a lookup of the prior address misses.

Source files
------------

// File: rtl/icache_responder_if.sv
// Fetch-side and refill-side signals of the instruction cache.
// The slave modport is the cache's view; the master modport drives it from the pipeline and memory side.
interface icache_responder_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        inval;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, inval, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, inval, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache: one-cycle hits from IDLE, single-word refills from FILL,
// global invalidate and a saturating miss counter.
module icache_responder #(
  parameter int SETS  = 16,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  icache_responder_if.slave bus,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t state, next_state;

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS];

  // Word address of the outstanding refill; the byte offset is always zero.
  logic [29:0]      miss_word_q;
  logic [CNT_W-1:0] miss_count_q;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] fill_tag;
  logic [IDX_W-1:0] fill_idx;
  logic             hit;
  logic             miss_start;
  logic             fill_done;

  assign req_tag  = bus.imemaddr[31:IDX_W+2];
  assign req_idx  = bus.imemaddr[IDX_W+1:2];
  assign fill_tag = miss_word_q[29:IDX_W];
  assign fill_idx = miss_word_q[IDX_W-1:0];

  assign miss_count = miss_count_q;

  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state   = state;
    hit          = 1'b0;
    miss_start   = 1'b0;
    fill_done    = 1'b0;
    bus.ihit     = 1'b0;
    bus.imemload = '0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    case (state)
      IDLE: begin
        hit      = bus.imemREN && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
        bus.ihit = hit;
        if (hit) bus.imemload = data_q[req_idx];
        if (bus.imemREN && !hit) begin
          miss_start = 1'b1;
          next_state = FILL;
        end
      end
      FILL: begin
        bus.iREN  = 1'b1;
        bus.iaddr = {miss_word_q, 2'b00};
        if (!bus.iwait) begin
          fill_done  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: the frame arrays are reset explicitly because the cache contract requires zeroed tags and data after reset;
  // this keeps them in flops rather than a RAM macro.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
      for (int i = 0; i < SETS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (fill_done) begin
        valid_q[fill_idx] <= 1'b1;
        tag_q[fill_idx]   <= fill_tag;
        data_q[fill_idx]  <= bus.iload;
      end
      // Placed after the fill write so a coincident invalidate leaves the new frame invalid.
      if (bus.inval) valid_q <= '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      miss_word_q  <= '0;
      miss_count_q <= '0;
    end else if (miss_start) begin
      miss_word_q <= bus.imemaddr[31:2];
      if (miss_count_q != {CNT_W{1'b1}}) miss_count_q <= miss_count_q + 1'b1;
    end
  end

endmodule
